// File: rtl/fft_band_energy.sv
// fft_band_energy: approximate-magnitude band energy accumulator for the streamed 1024-pt FFT spectrum.
// Double-buffered band banks, serial peak scan and a registered band read port.
module fft_band_energy #(
  parameter int N_LOG2    = 10,
  parameter int DATA_W    = 16,
  parameter int BAND_LOG2 = 4,
  parameter int ACC_W     = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dv,
  input  logic [N_LOG2-1:0]    xk_index,
  input  logic [DATA_W-1:0]    xk_re,
  input  logic [DATA_W-1:0]    xk_im,
  input  logic [BAND_LOG2-1:0] band_sel,
  output logic [ACC_W-1:0]     band_mag,
  output logic                 frame_valid,
  output logic [7:0]           frame_count,
  output logic [BAND_LOG2-1:0] peak_band,
  output logic [ACC_W-1:0]     peak_mag,
  output logic                 overrun
);

  localparam int NB = 1 << BAND_LOG2;
  localparam logic [N_LOG2-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH, SCAN} state_t;

  // Asynchronous assert, synchronised deassert.
  logic [1:0] rst_pipe;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_sync_n = rst_pipe[1];

  // in_frame tracks frame membership independently of the FSM, so bins of the
  // next frame arriving during PUBLISH/SCAN are still collected.
  logic start, last, restart, end_evt, accept, in_frame;

  assign start   = dv && (xk_index == '0);
  assign last    = dv && (xk_index == IDX_LAST);
  assign restart = start && in_frame;
  assign end_evt = last && in_frame;
  assign accept  = dv && (in_frame || start) && !xk_index[N_LOG2-1];

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  logic                 s1_valid, s2_valid;
  logic [BAND_LOG2-1:0] s1_band, s2_band;
  logic [DATA_W-1:0]    s1_re, s1_im;
  logic [DATA_W:0]      s2_mag;
  logic [DATA_W-1:0]    mag_max, mag_min, mag_half;

  always_comb begin
    mag_max  = (s1_re >= s1_im) ? s1_re : s1_im;
    mag_min  = (s1_re >= s1_im) ? s1_im : s1_re;
    mag_half = mag_min >> 1;
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      in_frame <= 1'b0;
      s1_valid <= 1'b0;
      s1_band  <= '0;
      s1_re    <= '0;
      s1_im    <= '0;
      s2_valid <= 1'b0;
      s2_band  <= '0;
      s2_mag   <= '0;
    end else begin
      if (start)        in_frame <= 1'b1;
      else if (end_evt) in_frame <= 1'b0;
      s1_valid <= accept;
      s1_band  <= xk_index[N_LOG2-2 -: BAND_LOG2];
      s1_re    <= abs_val(xk_re);
      s1_im    <= abs_val(xk_im);
      // A restart discards the aborted frame's bin still in flight.
      s2_valid <= s1_valid && !restart;
      s2_band  <= s1_band;
      s2_mag   <= {1'b0, mag_max} + {1'b0, mag_half};
    end
  end

  logic [ACC_W-1:0] work [NB];
  logic [ACC_W-1:0] pub  [NB];
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_sat;

  always_comb begin
    sum_ext = {1'b0, work[s2_band]} + {{(ACC_W-DATA_W){1'b0}}, s2_mag};
    sum_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
  end

  state_t               state;
  logic [1:0]           drain;
  logic [BAND_LOG2-1:0] scan_idx, best_idx;
  logic [ACC_W-1:0]     best_mag;
  logic                 scan_gt;

  assign scan_gt = pub[scan_idx] > best_mag;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state       <= IDLE;
      drain       <= '0;
      scan_idx    <= '0;
      best_idx    <= '0;
      best_mag    <= '0;
      band_mag    <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      peak_band   <= '0;
      peak_mag    <= '0;
      overrun     <= 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
        work[i] <= '0;
        pub[i]  <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      band_mag    <= pub[band_sel];
      drain       <= {drain[0], end_evt};
      if (restart) overrun <= 1'b1;

      // A next-frame bin reaching S3 during PUBLISH lands in the freshly cleared bank.
      if (state == PUBLISH) begin
        for (int unsigned i = 0; i < NB; i++) begin
          pub[i]  <= work[i];
          work[i] <= '0;
        end
        if (s2_valid) work[s2_band] <= {{(ACC_W-DATA_W-1){1'b0}}, s2_mag};
      end else if (restart) begin
        for (int unsigned i = 0; i < NB; i++) work[i] <= '0;
      end else if (s2_valid) begin
        work[s2_band] <= sum_sat;
      end

      case (state)
        IDLE: begin
          if (start || in_frame) state <= ACCUM;
        end
        ACCUM: begin
          if (drain[1]) state <= PUBLISH;
        end
        PUBLISH: begin
          state    <= SCAN;
          scan_idx <= '0;
          best_idx <= '0;
          best_mag <= '0;
        end
        SCAN: begin
          if (scan_gt) begin
            best_idx <= scan_idx;
            best_mag <= pub[scan_idx];
          end
          scan_idx <= scan_idx + BAND_LOG2'(1);
          if (scan_idx == '1) begin
            state       <= IDLE;
            peak_band   <= scan_gt ? scan_idx : best_idx;
            peak_mag    <= scan_gt ? pub[scan_idx] : best_mag;
            frame_valid <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_band_energy.sv
// Self-checking bench for fft_band_energy: directed and random frames against a
// frame-level reference model, with a 24-bit and a 20-bit accumulator instance.
module tb_fft_band_energy;

  localparam int N     = 1024;
  localparam int HALF  = N / 2;
  localparam int NB    = 16;
  localparam int BPB   = HALF / NB;
  localparam longint MAX_A = (64'd1 << 24) - 1;
  localparam longint MAX_B = (64'd1 << 20) - 1;

  logic        clk;
  logic        rst_n;
  logic        dv;
  logic [9:0]  xk_index;
  logic [15:0] xk_re, xk_im;
  logic [3:0]  band_sel;

  logic [23:0] band_mag_a, peak_mag_a;
  logic [19:0] band_mag_b, peak_mag_b;
  logic        frame_valid_a, frame_valid_b, overrun_a, overrun_b;
  logic [7:0]  frame_count_a, frame_count_b;
  logic [3:0]  peak_band_a, peak_band_b;

  fft_band_energy #(.N_LOG2(10), .DATA_W(16), .BAND_LOG2(4), .ACC_W(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .dv(dv), .xk_index(xk_index), .xk_re(xk_re), .xk_im(xk_im),
    .band_sel(band_sel), .band_mag(band_mag_a), .frame_valid(frame_valid_a),
    .frame_count(frame_count_a), .peak_band(peak_band_a), .peak_mag(peak_mag_a),
    .overrun(overrun_a)
  );

  fft_band_energy #(.N_LOG2(10), .DATA_W(16), .BAND_LOG2(4), .ACC_W(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .dv(dv), .xk_index(xk_index), .xk_re(xk_re), .xk_im(xk_im),
    .band_sel(band_sel), .band_mag(band_mag_b), .frame_valid(frame_valid_b),
    .frame_count(frame_count_b), .peak_band(peak_band_b), .peak_mag(peak_mag_b),
    .overrun(overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Frame contents and reference results
  int     fr_re [N];
  int     fr_im [N];
  longint exp_a [NB];
  longint exp_b [NB];
  int     pk_a, pk_b;
  int     exp_cnt = 0;
  int     exp_ovr = 0;
  longint last_cyc;

  longint ex_cyc[$], ex_pb_a[$], ex_pm_a[$], ex_pb_b[$], ex_pm_b[$], ex_cnt[$];
  longint qa_cyc[$], qa_pb[$], qa_pm[$], qa_cnt[$];
  longint qb_cyc[$], qb_pb[$], qb_pm[$], qb_cnt[$];

  always @(negedge clk) begin
    if (frame_valid_a) begin
      qa_cyc.push_back(cyc); qa_pb.push_back(peak_band_a);
      qa_pm.push_back(peak_mag_a); qa_cnt.push_back(frame_count_a);
    end
    if (frame_valid_b) begin
      qb_cyc.push_back(cyc); qb_pb.push_back(peak_band_b);
      qb_pm.push_back(peak_mag_b); qb_cnt.push_back(frame_count_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endtask

  task automatic set_range(input int lo, input int hi, input int re, input int im);
    for (int i = lo; i <= hi; i++) begin
      fr_re[i] = re;
      fr_im[i] = im;
    end
  endtask

  task automatic random_frame();
    logic signed [15:0] r;
    for (int i = 0; i < N; i++) begin
      r = 16'($urandom());
      fr_re[i] = int'(r);
      r = 16'($urandom());
      fr_im[i] = int'(r);
    end
  endtask

  // Energy of a band = saturating sum of max+min/2 over its positive-frequency bins.
  task automatic run_model();
    longint sum [NB];
    int ar, ai;
    for (int b = 0; b < NB; b++) sum[b] = 0;
    for (int i = 0; i < HALF; i++) begin
      ar = (fr_re[i] < 0) ? -fr_re[i] : fr_re[i];
      ai = (fr_im[i] < 0) ? -fr_im[i] : fr_im[i];
      sum[i / BPB] += (ar > ai) ? (ar + ai / 2) : (ai + ar / 2);
    end
    pk_a = 0;
    pk_b = 0;
    for (int b = 0; b < NB; b++) begin
      exp_a[b] = (sum[b] > MAX_A) ? MAX_A : sum[b];
      exp_b[b] = (sum[b] > MAX_B) ? MAX_B : sum[b];
      if (exp_a[b] > exp_a[pk_a]) pk_a = b;
      if (exp_b[b] > exp_b[pk_b]) pk_b = b;
    end
  endtask

  task automatic zero_expect();
    for (int b = 0; b < NB; b++) begin
      exp_a[b] = 0;
      exp_b[b] = 0;
    end
    pk_a = 0;
    pk_b = 0;
  endtask

  task automatic push_expect();
    exp_cnt = (exp_cnt + 1) % 256;
    ex_cyc.push_back(last_cyc + 20);
    ex_pb_a.push_back(pk_a); ex_pm_a.push_back(exp_a[pk_a]);
    ex_pb_b.push_back(pk_b); ex_pm_b.push_back(exp_b[pk_b]);
    ex_cnt.push_back(exp_cnt);
  endtask

  task automatic stream(input int first, input int last, input int gap_pct, input int rst_at);
    for (int i = first; i <= last; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        dv = 1'b0;
        xk_index = 10'($urandom_range(1, 1022));
        xk_re = 16'($urandom());
        xk_im = 16'($urandom());
        tick();
      end
      if (i == rst_at) rst_n = 1'b0;
      else if (i == rst_at + 1) rst_n = 1'b1;
      dv = 1'b1;
      xk_index = 10'(i);
      xk_re = 16'(fr_re[i]);
      xk_im = 16'(fr_im[i]);
      last_cyc = cyc;
      tick();
    end
    dv = 1'b0;
  endtask

  task automatic drain_pulses();
    repeat (40) tick();
    check("fv_count_a", qa_cyc.size(), ex_cyc.size());
    check("fv_count_b", qb_cyc.size(), ex_cyc.size());
    for (int k = 0; k < ex_cyc.size(); k++) begin
      if (k < qa_cyc.size()) begin
        check("fv_cycle_a", qa_cyc[k], ex_cyc[k]);
        check("peak_band_a", qa_pb[k], ex_pb_a[k]);
        check("peak_mag_a", qa_pm[k], ex_pm_a[k]);
        check("frame_count_a", qa_cnt[k], ex_cnt[k]);
      end
      if (k < qb_cyc.size()) begin
        check("fv_cycle_b", qb_cyc[k], ex_cyc[k]);
        check("peak_band_b", qb_pb[k], ex_pb_b[k]);
        check("peak_mag_b", qb_pm[k], ex_pm_b[k]);
        check("frame_count_b", qb_cnt[k], ex_cnt[k]);
      end
    end
    ex_cyc.delete(); ex_pb_a.delete(); ex_pm_a.delete();
    ex_pb_b.delete(); ex_pm_b.delete(); ex_cnt.delete();
    qa_cyc.delete(); qa_pb.delete(); qa_pm.delete(); qa_cnt.delete();
    qb_cyc.delete(); qb_pb.delete(); qb_pm.delete(); qb_cnt.delete();
  endtask

  task automatic read_bands();
    for (int b = 0; b < NB; b++) begin
      band_sel = 4'(b);
      tick();
      check("band_mag_a", band_mag_a, exp_a[b]);
      check("band_mag_b", band_mag_b, exp_b[b]);
    end
    check("overrun_a", overrun_a, exp_ovr);
    check("overrun_b", overrun_b, exp_ovr);
    check("frame_count_a_now", frame_count_a, exp_cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, {band_mag_a, peak_mag_a, peak_band_a, frame_count_a, frame_valid_a, overrun_a}, 0);
    check({tag, "_b"}, {band_mag_b, peak_mag_b, peak_band_b, frame_count_b, frame_valid_b, overrun_b}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    exp_cnt = 0;
    exp_ovr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; dv = 1'b0; xk_index = '0; xk_re = '0; xk_im = '0; band_sel = '0;

    // Reset held with random activity, then idle traffic that never forms a frame
    for (int k = 0; k < 12; k++) begin
      dv = 1'($urandom()); xk_index = 10'($urandom()); xk_re = 16'($urandom());
      xk_im = 16'($urandom()); band_sel = 4'($urandom());
      tick();
      check_zero("reset_hold");
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      dv = 1'($urandom()); xk_index = 10'($urandom_range(1, 1022));
      xk_re = 16'($urandom()); xk_im = 16'($urandom()); band_sel = 4'($urandom());
      tick();
      check_zero("post_reset");
    end
    dv = 1'b0;
    repeat (4) tick();

    // Constant real input on every bin
    clear_frame(); set_range(0, N-1, 100, 0);
    run_model(); stream(0, N-1, 0, -1); push_expect(); drain_pulses(); read_bands();

    // Full-scale negative in band 3 only; saturates on the 20-bit instance
    clear_frame(); set_range(96, 127, -32768, -32768);
    run_model(); stream(0, N-1, 0, -1); push_expect(); drain_pulses(); read_bands();

    // Energy only in negative-frequency bins
    clear_frame(); set_range(512, N-1, 32767, 32767);
    run_model(); stream(0, N-1, 0, -1); push_expect(); drain_pulses(); read_bands();

    // Random frames with idle gaps
    for (int f = 0; f < 3; f++) begin
      random_frame();
      run_model(); stream(0, N-1, 10, -1); push_expect(); drain_pulses(); read_bands();
    end

    // Back-to-back frames: second frame accumulates while the first is scanned
    random_frame(); run_model(); stream(0, N-1, 0, -1); push_expect();
    random_frame(); run_model(); stream(0, N-1, 5, -1); push_expect();
    drain_pulses(); read_bands();

    // Abort at bin 200 followed by a complete frame
    do_reset();
    clear_frame(); set_range(0, N-1, 10, 0);
    run_model(); stream(0, 199, 0, -1); stream(0, N-1, 0, -1);
    exp_ovr = 1; push_expect(); drain_pulses(); read_bands();

    // Reset pulse in the middle of a frame, then a clean frame
    clear_frame(); set_range(0, N-1, 50, 0);
    stream(0, N-1, 0, 300);
    exp_cnt = 0; exp_ovr = 0; zero_expect();
    drain_pulses(); read_bands(); check_zero("after_mid_reset");
    run_model(); stream(0, N-1, 0, -1); push_expect(); drain_pulses(); read_bands();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
